// File: rtl/four_by_four_node_patch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : four_by_four_node_patch_pkg
// Brief    : Shared node type, fixed-point constants and saturation helper
//            for the 4x4 wave-equation mesh patch.
// Revision : 1.0
// ============================================================================
package four_by_four_node_patch_pkg;

  typedef logic signed [17:0] node_t;

  localparam int FRAC_BITS = 17;

  // Saturation bounds expressed at the 22-bit update width
  localparam logic signed [21:0] SAT_MAX = 22'sh01FFFF;
  localparam logic signed [21:0] SAT_MIN = -22'sh020000;

  function automatic node_t saturate(input logic signed [21:0] v);
    node_t r;
    if (v > SAT_MAX) begin
      r = 18'sh1FFFF;
    end else if (v < SAT_MIN) begin
      r = 18'sh20000;
    end else begin
      r = v[17:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/four_by_four_node_patch_wave_node.sv
`default_nettype none
// ============================================================================
// Module   : wave_node
// Brief    : One mesh node: current/previous amplitude registers plus the
//            damped discrete wave-equation update datapath.
// Revision : 1.0
// ============================================================================
module wave_node
  import four_by_four_node_patch_pkg::*;
#(
  parameter int DAMP_SHIFT = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] init,
  input  logic [17:0] n,
  input  logic [17:0] s,
  input  logic [17:0] e,
  input  logic [17:0] w,
  input  logic [17:0] rho,
  input  logic        enable,
  output logic [17:0] u
);

  node_t r_u;
  node_t r_up;

  logic signed [20:0] w_lap;
  logic signed [38:0] w_prod;
  logic signed [21:0] w_k;
  logic signed [21:0] w_diff;
  logic signed [21:0] w_damp;
  logic signed [21:0] w_next;

  // 21 bits hold four 18-bit neighbours minus 4u without overflow
  assign w_lap  = 21'($signed(n)) + 21'($signed(s)) + 21'($signed(e)) + 21'($signed(w))
                - (21'(r_u) <<< 2);
  assign w_prod = 39'($signed(rho)) * 39'(w_lap);
  assign w_k    = 22'(w_prod >>> FRAC_BITS);
  assign w_diff = 22'(r_u) - 22'(r_up);
  assign w_damp = w_diff >>> DAMP_SHIFT;
  assign w_next = w_k + (22'(r_u) <<< 1) - 22'(r_up) - w_damp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_u  <= init;
      r_up <= init;
    end else if (enable) begin
      r_up <= r_u;
      r_u  <= saturate(w_next);
    end
  end

  assign u = r_u;

endmodule
`default_nettype wire

// File: rtl/four_by_four_node_patch.sv
`default_nettype none
// ============================================================================
// Module   : four_by_four_node_patch
// Brief    : 4x4 tile of a 2-D damped wave-equation mesh with one scalar per
//            side for neighbour exchange and a centre-average output.
// Revision : 1.0
// ============================================================================
module four_by_four_node_patch
  import four_by_four_node_patch_pkg::*;
#(
  parameter int DAMP_SHIFT = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] init,
  input  logic [17:0] u_1_right,
  input  logic [17:0] u_1_left_1,
  input  logic [17:0] u_1_up_1,
  input  logic [17:0] u_1_down_1,
  input  logic [17:0] rho,
  input  logic        enable,
  output logic [17:0] data_out,
  output logic [31:0] middle
);

  logic [17:0] w_u [4][4];
  logic signed [19:0] w_sum;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      logic [17:0] w_n, w_s, w_e, w_w;

      // Edge nodes take the single side scalar of the adjacent patch
      if (r == 0) begin : g_n_edge
        assign w_n = u_1_up_1;
      end else begin : g_n_int
        assign w_n = w_u[r-1][c];
      end

      if (r == 3) begin : g_s_edge
        assign w_s = u_1_down_1;
      end else begin : g_s_int
        assign w_s = w_u[r+1][c];
      end

      if (c == 0) begin : g_w_edge
        assign w_w = u_1_left_1;
      end else begin : g_w_int
        assign w_w = w_u[r][c-1];
      end

      if (c == 3) begin : g_e_edge
        assign w_e = u_1_right;
      end else begin : g_e_int
        assign w_e = w_u[r][c+1];
      end

      wave_node #(
        .DAMP_SHIFT (DAMP_SHIFT)
      ) u_node (
        .clock  (clock),
        .reset  (reset),
        .init   (init),
        .n      (w_n),
        .s      (w_s),
        .e      (w_e),
        .w      (w_w),
        .rho    (rho),
        .enable (enable),
        .u      (w_u[r][c])
      );
    end
  end

  assign w_sum = 20'($signed(w_u[1][1])) + 20'($signed(w_u[1][2]))
               + 20'($signed(w_u[2][1])) + 20'($signed(w_u[2][2]));

  // Top 18 bits of the 20-bit sum are the arithmetic divide-by-four
  assign data_out = w_sum[19:2];
  assign middle   = {{14{data_out[17]}}, data_out};

endmodule
`default_nettype wire

// File: tb/tb_four_by_four_node_patch.sv
`default_nettype none
// ============================================================================
// Module   : tb_four_by_four_node_patch
// Brief    : Self-checking bench with a behavioural mesh model and scoreboard.
// Revision : 1.0
// ============================================================================
module tb_four_by_four_node_patch;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [17:0] init, right_s, left_s, up_s, down_s, rho;
  logic [17:0] data_out;
  logic [31:0] middle;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int mu  [4][4];
  int mup [4][4];
  int run1 [8];

  four_by_four_node_patch #(.DAMP_SHIFT(9)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .init       (init),
    .u_1_right  (right_s),
    .u_1_left_1 (left_s),
    .u_1_up_1   (up_s),
    .u_1_down_1 (down_s),
    .rho        (rho),
    .enable     (enable),
    .data_out   (data_out),
    .middle     (middle)
  );

  always #5 clock = ~clock;

  function automatic int s18(input logic [17:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return int'(v);
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mu[r][c]  = s18(init);
        mup[r][c] = s18(init);
      end
  endfunction

  function automatic void model_step();
    int nu [4][4];
    longint lap, k, d;
    int nn, ss, ee, ww;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        nn  = (r == 0) ? s18(up_s)   : mu[r-1][c];
        ss  = (r == 3) ? s18(down_s) : mu[r+1][c];
        ww  = (c == 0) ? s18(left_s) : mu[r][c-1];
        ee  = (c == 3) ? s18(right_s): mu[r][c+1];
        lap = longint'(nn) + ss + ee + ww - 4 * longint'(mu[r][c]);
        k   = (longint'(s18(rho)) * lap) >>> 17;
        d   = (longint'(mu[r][c]) - mup[r][c]) >>> 9;
        nu[r][c] = sat(k + 2 * longint'(mu[r][c]) - mup[r][c] - d);
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mup[r][c] = mu[r][c];
        mu[r][c]  = nu[r][c];
      end
  endfunction

  function automatic int model_out();
    return (mu[1][1] + mu[1][2] + mu[2][1] + mu[2][2]) >>> 2;
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: model advances with the presented inputs, result is queued,
  // then popped and compared after the edge.
  task automatic step_cycle(input string tag, output int got);
    int e;
    if (enable) model_step();
    exp_q.push_back(model_out());
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    got = s18(data_out);
    check(tag, got, e);
    check({tag, "_mid"}, int'(middle), e);
  endtask

  task automatic do_reset(input logic [17:0] iv);
    init   = iv;
    enable = 1'b0;
    reset  = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    check("reset_out", s18(data_out), s18(iv));
    reset = 1'b0;
  endtask

  task automatic set_sides(input logic [17:0] v);
    right_s = v; left_s = v; up_s = v; down_s = v;
  endtask

  initial begin
    int got;
    reset = 1'b0; enable = 1'b0;
    init = '0; rho = '0;
    set_sides('0);

    // Reset state and hold with enable low
    rho = 18'h04000;
    do_reset(18'h08000);
    check("reset_mid_const", int'(middle), 32'h0000_8000);
    for (int i = 0; i < 10; i++) step_cycle("hold", got);
    check("hold_const", got, 32'h8000);

    // All zero stays zero
    do_reset(18'h00000);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) step_cycle("zero", got);
    check("zero_const", got, 0);

    // Uniform field with matching sides: Laplacian is zero
    set_sides(18'h08000);
    do_reset(18'h08000);
    enable = 1'b1;
    for (int i = 0; i < 12; i++) step_cycle("flat", got);
    check("flat_const", got, 32'h8000);

    // Uniform field with zero sides: edges pull down
    set_sides(18'h00000);
    do_reset(18'h08000);
    enable = 1'b1;
    step_cycle("edge_s1", got);
    check("edge_s1_const", got, 32'h8000);
    check("corner_s1", mu[0][0], 32'h6000);
    check("side_s1", mu[0][1], 32'h7000);
    step_cycle("edge_s2", got);
    check("edge_s2_const", got, 32'h7C00);
    for (int i = 0; i < 10; i++) step_cycle("edge_run", got);

    // Saturation stress
    rho = 18'h1FFFF;
    set_sides(18'h1FFFF);
    do_reset(18'h1FFFF);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step_cycle("sat_flat", got);
    up_s   = 18'h20000;
    down_s = 18'h20000;
    for (int i = 0; i < 20; i++) step_cycle("sat_swing", got);

    // Asynchronous reset mid-run, then replay must match the first run
    rho = 18'h04000;
    set_sides(18'h00000);
    do_reset(18'h08000);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step_cycle("run1", got);
      run1[i] = got;
    end
    @(negedge clock);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_out", s18(data_out), 32'h8000);
    check("async_rst_mid", int'(middle), 32'h0000_8000);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step_cycle("run2", got);
      check("replay", got, run1[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
